pipeline_ex_md: RTL and testbench

- Parametrised successor EX stage for the MIPS pipeline.
- Performs operand forwarding and immediate/shamt selection in front of the existing combinational ALU.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, supporting MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- Sits between the ID/EX and EX/MEM registers and raises a stall to the hazard unit while the MD unit is busy.

---
 rtl/pipeline_ex_md.sv | 201 ++++++++++++++++++++
 tb/tb_pipeline_ex_md.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ex_md.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ex_md
// Description : MIPS EX stage with operand forwarding and immediate/shamt
//               selection, plus an iterative multiply/divide unit that owns
//               the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ex_md #(
    parameter int WIDTH   = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         ForwardA,
    input  logic [1:0]         ForwardB,
    input  logic [WIDTH-1:0]   MEMWBdata,
    input  logic [WIDTH-1:0]   EXMEMdata,
    input  logic [WIDTH-1:0]   EX_dataA,
    input  logic [WIDTH-1:0]   EX_dataB,
    input  logic [IMM_W-1:0]   EX_imm,
    input  logic [SHAMT_W-1:0] EX_shamt,
    input  logic               EX_ALUSrc1,
    input  logic               EX_ALUSrc2,
    input  logic               EX_EXTOp,
    input  logic               EX_LUOp,
    input  logic [2:0]         md_op,
    input  logic [1:0]         md_rd,
    input  logic               flush,
    output logic [WIDTH-1:0]   EX_opA,
    output logic [WIDTH-1:0]   EX_opB,
    output logic [WIDTH-1:0]   EX_rt_postForward,
    output logic [WIDTH-1:0]   md_result,
    output logic               md_busy,
    output logic               md_stall
);

    localparam int         c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_MULTU = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_DIVU  = 3'b100;
    localparam logic [2:0] c_OP_MTHI  = 3'b101;
    localparam logic [2:0] c_OP_MTLO  = 3'b110;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_a_src;
    logic [WIDTH-1:0]   w_fwd_b;
    logic [WIDTH-1:0]   w_ext_imm;

    // Operand path: Src1 picks the base for A, then forwarding may replace it.
    always_comb begin
        w_a_src = EX_ALUSrc1 ? {{(WIDTH-SHAMT_W){1'b0}}, EX_shamt} : EX_dataA;
        case (ForwardA)
            2'b00:   EX_opA = w_a_src;
            2'b01:   EX_opA = MEMWBdata;
            2'b10:   EX_opA = EXMEMdata;
            default: EX_opA = '0;
        endcase

        case (ForwardB)
            2'b00:   w_fwd_b = EX_dataB;
            2'b01:   w_fwd_b = MEMWBdata;
            2'b10:   w_fwd_b = EXMEMdata;
            default: w_fwd_b = '0;
        endcase

        if (EX_LUOp)
            w_ext_imm = {EX_imm, {(WIDTH-IMM_W){1'b0}}};
        else if (EX_EXTOp)
            w_ext_imm = {{(WIDTH-IMM_W){EX_imm[IMM_W-1]}}, EX_imm};
        else
            w_ext_imm = {{(WIDTH-IMM_W){1'b0}}, EX_imm};

        EX_opB            = EX_ALUSrc2 ? w_ext_imm : w_fwd_b;
        EX_rt_postForward = w_fwd_b;
    end

    logic               w_signed;
    logic               w_start;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod_fin;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    always_comb begin
        w_signed = (md_op == c_OP_MULT) || (md_op == c_OP_DIV);
        w_start  = (md_op == c_OP_MULT) || (md_op == c_OP_MULTU) ||
                   (md_op == c_OP_DIV)  || (md_op == c_OP_DIVU);
        w_mag_a  = (w_signed && EX_opA[WIDTH-1]) ? -EX_opA : EX_opA;
        w_mag_b  = (w_signed && EX_opB[WIDTH-1]) ? -EX_opB : EX_opB;

        // r_acc holds {partial product, multiplier} or {remainder, quotient}.
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb & {WIDTH{r_acc[0]}}};
        w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_diff  = w_div_shift - {1'b0, r_opb};

        if (r_is_div) begin
            if (!w_div_diff[WIDTH])
                w_acc_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
                w_acc_next = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end

        w_prod_fin = r_q_neg ? -w_acc_next : w_acc_next;
        if (r_is_div) begin
            // Divide by zero leaves the dividend magnitude in the remainder half.
            w_fin_lo = r_div0  ? {WIDTH{1'b1}} :
                       r_q_neg ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
            w_fin_hi = r_r_neg ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];
        end else begin
            w_fin_lo = w_prod_fin[WIDTH-1:0];
            w_fin_hi = w_prod_fin[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!flush) begin
                        if (w_start) begin
                            r_state  <= c_RUN;
                            r_cnt    <= '0;
                            r_is_div <= (md_op == c_OP_DIV) || (md_op == c_OP_DIVU);
                            r_q_neg  <= w_signed & (EX_opA[WIDTH-1] ^ EX_opB[WIDTH-1]);
                            r_r_neg  <= w_signed & EX_opA[WIDTH-1];
                            r_div0   <= (EX_opB == '0);
                            r_opb    <= w_mag_b;
                            r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                        end else if (md_op == c_OP_MTHI) begin
                            r_hi <= EX_opA;
                        end else if (md_op == c_OP_MTLO) begin
                            r_lo <= EX_opA;
                        end
                    end
                end
                c_RUN: begin
                    if (flush) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_state <= c_IDLE;
                            r_hi    <= w_fin_hi;
                            r_lo    <= w_fin_lo;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        md_busy  = (r_state == c_RUN);
        md_stall = md_busy && ((md_op != 3'b000) || (md_rd != 2'b00));
        case (md_rd)
            2'b01:   md_result = r_hi;
            2'b10:   md_result = r_lo;
            default: md_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ex_md.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ex_md
// Description : Directed self-checking bench for pipeline_ex_md with an
//               arithmetic reference model of operands and HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ex_md;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    ForwardA = '0, ForwardB = '0;
    logic [W-1:0]  MEMWBdata = '0, EXMEMdata = '0, EX_dataA = '0, EX_dataB = '0;
    logic [15:0]   EX_imm = '0;
    logic [4:0]    EX_shamt = '0;
    logic          EX_ALUSrc1 = 1'b0, EX_ALUSrc2 = 1'b0, EX_EXTOp = 1'b0, EX_LUOp = 1'b0;
    logic [2:0]    md_op = '0;
    logic [1:0]    md_rd = '0;
    logic          flush = 1'b0;
    logic [W-1:0]  EX_opA, EX_opB, EX_rt_postForward, md_result;
    logic          md_busy, md_stall;

    always #5 clk = ~clk;

    pipeline_ex_md #(.WIDTH(W), .IMM_W(16), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .MEMWBdata(MEMWBdata), .EXMEMdata(EXMEMdata),
        .EX_dataA(EX_dataA), .EX_dataB(EX_dataB),
        .EX_imm(EX_imm), .EX_shamt(EX_shamt),
        .EX_ALUSrc1(EX_ALUSrc1), .EX_ALUSrc2(EX_ALUSrc2),
        .EX_EXTOp(EX_EXTOp), .EX_LUOp(EX_LUOp),
        .md_op(md_op), .md_rd(md_rd), .flush(flush),
        .EX_opA(EX_opA), .EX_opB(EX_opB), .EX_rt_postForward(EX_rt_postForward),
        .md_result(md_result), .md_busy(md_busy), .md_stall(md_stall)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference operand selection.
    function automatic logic [31:0] f_fwd(input logic [1:0] sel, input logic [31:0] reg_val);
        case (sel)
            2'b00:   return reg_val;
            2'b01:   return MEMWBdata;
            2'b10:   return EXMEMdata;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] f_opA();
        return f_fwd(ForwardA, EX_ALUSrc1 ? {27'b0, EX_shamt} : EX_dataA);
    endfunction

    function automatic logic [31:0] f_opB();
        logic [31:0] imm;
        if (EX_LUOp)       imm = {EX_imm, 16'h0000};
        else if (EX_EXTOp) imm = {{16{EX_imm[15]}}, EX_imm};
        else               imm = {16'h0000, EX_imm};
        return EX_ALUSrc2 ? imm : f_fwd(ForwardB, EX_dataB);
    endfunction

    // Reference MD result as {HI, LO}, computed with native arithmetic.
    function automatic logic [63:0] f_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     ia, ib, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = ia / ib;
                r = ia % ib;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Model: a busy countdown and pending result, committed when it expires.
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left > 0) begin
            if (flush) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi <= m_pend[63:32];
                    m_lo <= m_pend[31:0];
                end
            end
        end else if (!flush) begin
            case (md_op)
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    m_pend <= f_md(md_op, f_opA(), f_opB());
                    m_left <= W;
                end
                3'd5:    m_hi <= f_opA();
                3'd6:    m_lo <= f_opA();
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_res;
        exp_res = (md_rd == 2'b01) ? m_hi : (md_rd == 2'b10) ? m_lo : 32'h0;
        chk("opA", EX_opA, f_opA());
        chk("opB", EX_opB, f_opB());
        chk("rt_postForward", EX_rt_postForward, f_fwd(ForwardB, EX_dataB));
        chk("md_result", md_result, exp_res);
        chk("md_busy", 32'(md_busy), 32'(m_left > 0));
        chk("md_stall", 32'(md_stall), 32'((m_left > 0) && (md_op != 3'd0 || md_rd != 2'd0)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int busy_cycles, output int stall_cycles);
        busy_cycles  = 0;
        stall_cycles = 0;
        while (md_busy && busy_cycles < 40) begin
            busy_cycles++;
            if (md_stall) stall_cycles++;
            tick();
        end
    endtask

    task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int nb, ns;
        EX_dataA = a;
        EX_dataB = b;
        md_op    = op;
        tick();
        md_op = 3'd0;
        md_rd = 2'b10;
        wait_idle(nb, ns);
        chk({name, " busy cycles"}, nb, 32);
        chk({name, " LO"}, md_result, elo);
        md_rd = 2'b01;
        #1 chk({name, " HI"}, md_result, ehi);
        md_rd = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb, ns;
        repeat (2) tick();
        md_rd = 2'b01;
        #1 chk("reset HI", md_result, 32'h0);
        md_rd = 2'b10;
        #1 chk("reset LO", md_result, 32'h0);
        chk("reset busy", 32'(md_busy), 32'h0);
        md_rd = 2'b00;
        reset = 1'b0;
        tick();

        // Operand path
        ForwardA = 2'b10; EXMEMdata = 32'h1234; EX_ALUSrc2 = 1'b1; EX_imm = 16'h8000;
        EX_EXTOp = 1'b1; ForwardB = 2'b01; MEMWBdata = 32'hCAFE_BABE;
        EX_dataA = 32'h77; EX_dataB = 32'h55;
        #1 chk("fwdA EXMEM", EX_opA, 32'h0000_1234);
        chk("imm sext", EX_opB, 32'hFFFF_8000);
        chk("rt fwd MEMWB", EX_rt_postForward, 32'hCAFE_BABE);
        tick();
        EX_LUOp = 1'b1; EX_imm = 16'h1234; ForwardA = 2'b00; EX_ALUSrc1 = 1'b1; EX_shamt = 5'h1F;
        #1 chk("lui imm", EX_opB, 32'h1234_0000);
        chk("shamt opA", EX_opA, 32'h0000_001F);
        tick();
        EX_LUOp = 1'b0; EX_EXTOp = 1'b0; EX_imm = 16'h8000; ForwardA = 2'b11;
        ForwardB = 2'b10; EX_ALUSrc2 = 1'b0;
        #1 chk("fwdA zero", EX_opA, 32'h0);
        chk("fwdB EXMEM", EX_opB, 32'h0000_1234);
        tick();
        EX_ALUSrc2 = 1'b1;
        #1 chk("imm zext", EX_opB, 32'h0000_8000);
        chk("rt ignores src2", EX_rt_postForward, 32'h0000_1234);
        tick();
        ForwardA = 2'b00; ForwardB = 2'b00; EX_ALUSrc1 = 1'b0; EX_ALUSrc2 = 1'b0;
        EX_imm = 16'h0; EX_shamt = 5'h0;
        tick();

        // MULT -7 * 3 with MFLO waiting behind it
        EX_dataA = 32'hFFFF_FFF9; EX_dataB = 32'd3; md_op = 3'd1;
        tick();
        md_op = 3'd0; md_rd = 2'b10;
        wait_idle(nb, ns);
        chk("mult stall cycles", ns, 32);
        chk("mult busy cycles", nb, 32);
        chk("mult LO", md_result, 32'hFFFF_FFEB);
        md_rd = 2'b01;
        #1 chk("mult HI", md_result, 32'hFFFF_FFFF);
        md_rd = 2'b00;

        run_md("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu 100/7", 3'd4, 32'd100, 32'd7, 32'h2, 32'hE);
        run_md("divu 5/0", 3'd4, 32'd5, 32'd0, 32'h5, 32'hFFFF_FFFF);
        run_md("div min/-1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Op arriving while busy is held and taken at the first idle edge
        EX_dataA = 32'd100; EX_dataB = 32'd7; md_op = 3'd2;
        tick();
        md_op = 3'd4;
        wait_idle(nb, ns);
        chk("held op stall cycles", ns, 32);
        md_rd = 2'b10;
        #1 chk("multu 100*7 LO", md_result, 32'h0000_02BC);
        md_rd = 2'b00;
        tick();
        md_op = 3'd0;
        chk("held op accepted", 32'(md_busy), 32'h1);
        md_rd = 2'b10;
        wait_idle(nb, ns);
        chk("held divu LO", md_result, 32'hE);
        md_rd = 2'b01;
        #1 chk("held divu HI", md_result, 32'h2);

        // MTHI with no same-edge bypass, then a flushed MULTU
        EX_dataA = 32'hA5A5_A5A5; md_op = 3'd5;
        #1 chk("mthi no bypass", md_result, 32'h2);
        tick();
        md_op = 3'd0;
        chk("mthi HI", md_result, 32'hA5A5_A5A5);
        md_rd = 2'b00;
        EX_dataA = 32'h1234_5678; EX_dataB = 32'h9; md_op = 3'd2;
        tick();
        md_op = 3'd0;
        repeat (9) tick();
        flush = 1'b1;
        chk("busy before flush", 32'(md_busy), 32'h1);
        tick();
        flush = 1'b0;
        chk("busy after flush", 32'(md_busy), 32'h0);
        md_rd = 2'b01;
        #1 chk("stall after flush", 32'(md_stall), 32'h0);
        chk("HI kept after flush", md_result, 32'hA5A5_A5A5);
        md_rd = 2'b00;

        // Flush in IDLE suppresses MTLO and accept
        flush = 1'b1; EX_dataA = 32'h1111; md_op = 3'd6;
        tick();
        md_op = 3'd1;
        tick();
        flush = 1'b0; md_op = 3'd0;
        chk("flush blocks accept", 32'(md_busy), 32'h0);
        md_rd = 2'b10;
        #1 chk("flush blocks mtlo", md_result, 32'hE);
        md_rd = 2'b00;

        // Reset in the middle of a MULT
        EX_dataA = 32'd5; EX_dataB = 32'd6; md_op = 3'd1;
        tick();
        md_op = 3'd0; md_rd = 2'b01;
        repeat (4) tick();
        reset = 1'b1;
        #1 chk("reset mid busy", 32'(md_busy), 32'h0);
        chk("reset mid stall", 32'(md_stall), 32'h0);
        chk("reset mid HI", md_result, 32'h0);
        md_rd = 2'b10;
        #1 chk("reset mid LO", md_result, 32'h0);
        tick();
        reset = 1'b0; md_rd = 2'b00;
        tick();
        run_md("multu ffffffff*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
